// File: rtl/demux1x2_buffered.sv
// Registered 1:2 valid/ready demux, one 2-entry FIFO per destination.
// Optional pop counters on out0/out1 when DEMUX1X2_STATS_EN is defined.
module demux1x2_buffered #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [n-1:0] in_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [n-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [n-1:0] out1_data
`ifdef DEMUX1X2_STATS_EN
    ,
    output logic [15:0]  out0_count,
    output logic [15:0]  out1_count
`endif
);

    logic [n-1:0] mem_q  [2][2];
    logic [n-1:0] mem_d  [2][2];
    logic [n-1:0] head_q [2];
    logic [n-1:0] head_d [2];
    logic [1:0]   cnt_q  [2];
    logic [1:0]   cnt_d  [2];
    logic [1:0]   wp_q, wp_d;
    logic [1:0]   rp_q, rp_d;
    logic [1:0]   vld, push, pop, ordy;

    assign ordy     = {out1_ready, out0_ready};
    assign in_ready = (cnt_q[in_sel] != 2'd2);

    // head register tracks the entry at the post-update read pointer,
    // so a push into an empty buffer is visible right after its edge
    always_comb begin
        vld    = '0;
        push   = '0;
        pop    = '0;
        wp_d   = wp_q;
        rp_d   = rp_q;
        mem_d  = mem_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        for (int i = 0; i < 2; i++) begin
            vld[i]  = (cnt_q[i] != 2'd0);
            push[i] = in_valid && in_ready && (in_sel == 1'(i));
            pop[i]  = vld[i] && ordy[i];
            if (push[i]) begin
                mem_d[i][wp_q[i]] = in_data;
            end
            wp_d[i]   = wp_q[i] ^ push[i];
            rp_d[i]   = rp_q[i] ^ pop[i];
            cnt_d[i]  = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            head_d[i] = mem_d[i][rp_d[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]    <= '0;
                head_q[i]   <= '0;
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]    <= cnt_d[i];
                head_q[i]   <= head_d[i];
                mem_q[i][0] <= mem_d[i][0];
                mem_q[i][1] <= mem_d[i][1];
            end
        end
    end

    assign out0_valid = vld[0];
    assign out1_valid = vld[1];
    assign out0_data  = head_q[0];
    assign out1_data  = head_q[1];

`ifdef DEMUX1X2_STATS_EN
    logic [15:0] pops_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pops_q[0] <= '0;
            pops_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop[i]) begin
                    pops_q[i] <= pops_q[i] + 16'd1;
                end
            end
        end
    end

    assign out0_count = pops_q[0];
    assign out1_count = pops_q[1];
`endif

endmodule

// File: doc/demux1x2_buffered.md
Name: demux1x2_buffered

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes on all sides; the inverse of the CPU datapath's 2:1 mux.
- Steers one producer stream to one of two consumers, selected per beat by `in_sel`. Example: memory response port routed to the fetch path (0) or the load path (1).
- Each destination has a 2-entry FIFO, so a stalled consumer never blocks beats destined for the other consumer.

Parameters:
- n, 32, data width in bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer beat present.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- in_sel  input  1  destination of the current beat: 0 -> out0, 1 -> out1.
- in_data  input  n  payload.
- out0_valid  output  1  out0 buffer non-empty.
- out0_ready  input  1  consumer 0 takes head entry.
- out0_data  output  n  head entry of out0 buffer.
- out1_valid  output  1  out1 buffer non-empty.
- out1_ready  input  1  consumer 1 takes head entry.
- out1_data  output  n  head entry of out1 buffer.

Behaviour:
- Reset: clk/rst as above; synchronous, active-high; sampled on clk rising edge. All buffer entries, outN_data and occupancy counts clear to 0; outN_valid=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: buffered beats are discarded; no partial transfer survives.
- Per-destination FIFO:
  - Depth 2, occupancy count 0..2, read/write pointers 1 bit each, wrapping 1->0.
  - Push and pop in the same cycle leave the count unchanged.
- in_ready: combinational = (count[in_sel] != 2). Independent of in_valid and outN_ready; no pop-through when full. A full buffer stalls only beats selected to it.
- Accept: in_valid && in_ready writes in_data into buffer[in_sel] at the write pointer. The other buffer is untouched.
- Pop: outN_valid && outN_ready advances read pointer N. outN_data is a registered buffer read (mux of 2 entries by read pointer) and is stable while outN_valid && !outN_ready.
- outN_valid = (countN != 0).
- Latency: a beat accepted at edge k appears on outN at edge k (visible in cycle k+1) if bufferN was empty. Otherwise it appears after the entries ahead of it drain.
- Ordering: FIFO order per destination. No ordering guarantee between destinations.
- Throughput: 1 beat/cycle per destination when its consumer holds ready=1.
- in_sel and in_data are don't-care when in_valid=0.
- X on in_sel while in_valid=1 is illegal. The bench asserts it never occurs.

Optional Feature:
- Macro: DEMUX1X2_STATS_EN.
- Defined: adds output ports out0_count and out1_count, each 16 bits.
  - Each increments by 1 on every completed pop of its output and wraps 0xFFFF -> 0x0000.
  - Both clear on rst.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles -> out0_valid=out1_valid=0, outN_data=0, in_ready=1.
- Single beat to 1: in_data=0xDEADBEEF, in_sel=1, out1_ready=1 -> out1_valid=1 with 0xDEADBEEF the next cycle for exactly 1 cycle; out0_valid stays 0.
- Backpressure on 0: out0_ready=0, push 0x11, 0x22 to sel 0 -> in_ready=0 for sel 0. A third beat sel=1 value 0x33 is still accepted and appears on out1. Then out0_ready=1 -> 0x11 then 0x22, in order.
- Streaming both: alternate sel 0/1 with values 0..15, both ready=1 -> out0 gets 0,2,..14 and out1 gets 1,3,..15; in_ready never drops.
- Reset mid-stream: with out0 holding 2 beats, assert rst for 1 cycle -> out0_valid=0 the next cycle and the old data never appears.
- Stats (DEMUX1X2_STATS_EN): 65537 pops on out0 -> out0_count=1; out1_count unchanged.
